// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, colour and per-pixel control types.
// Shared by vga_axis_counter and vga_timing_gen. Option: VGA_TEST_PATTERN_EN.
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } rgb12_t;

  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } pix_ctl_t;

  function automatic pix_ctl_t ctl_rst();
    pix_ctl_t c;
    c    = '0;
    c.hs = ~SYNC_ACTIVE;
    c.vs = ~SYNC_ACTIVE;
    return c;
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  // Bar index bits map straight onto R, G, B full scale.
  function automatic rgb12_t bar_color(
    input logic [2:0] i
  );
    rgb12_t c;
    c.r = {4{i[0]}};
    c.g = {4{i[1]}};
    c.b = {4{i[2]}};
    return c;
  endfunction
`endif

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis, 0..MAX wrapping, with sync window decode.
// Ports: clk, rst_n, en in; wrap (en at MAX), cnt [9:0], sync (in window) out.
module vga_axis_counter #(
  parameter int MAX        = 799,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       wrap,
  output logic [9:0] cnt,
  output logic       sync
);

  assign wrap = en && (cnt == 10'(MAX));
  assign sync = (cnt >= 10'(SYNC_START)) &&
                (cnt <= 10'(SYNC_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 10'd1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster driver; clk_50 -> pixel_clk/pix_en, X/Y, syncs, pin RGB.
// In: clk_50, rst_n, pixel_color. Out: pixel_clk, pix_en, X_pix, Y_pix, H/V_visible,
// pixel_cnt, frame_start, VGA_BUS_R/G/B, VGA_HS, VGA_VS. Option: VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS_P   = H_VIS,
  parameter int H_FP_P    = H_FP,
  parameter int H_SYNC_P  = H_SYNC,
  parameter int H_BP_P    = H_BP,
  parameter int V_VIS_P   = V_VIS,
  parameter int V_FP_P    = V_FP,
  parameter int V_SYNC_P  = V_SYNC,
  parameter int V_BP_P    = V_BP,
  parameter int COLOR_DLY = 1
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic [11:0] pixel_color,
  output logic        pixel_clk,
  output logic        pix_en,
  output logic [9:0]  X_pix,
  output logic [9:0]  Y_pix,
  output logic        H_visible,
  output logic        V_visible,
  output logic [9:0]  pixel_cnt,
  output logic        frame_start,
  output logic [3:0]  VGA_BUS_R,
  output logic [3:0]  VGA_BUS_G,
  output logic [3:0]  VGA_BUS_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam int HT = H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam int VT = V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P;

  logic h_wrap, v_wrap, v_en;
  logic h_sync, v_sync;

  // pix_en lags the toggle so it is high while pixel_clk is low,
  // i.e. in the clk_50 cycle just before pixel_clk rises.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      pixel_clk <= 1'b0;
      pix_en    <= 1'b0;
    end else begin
      pixel_clk <= ~pixel_clk;
      pix_en    <= pixel_clk;
    end
  end

  assign v_en = pix_en && h_wrap;

  vga_axis_counter #(
    .MAX        (HT - 1),
    .SYNC_START (H_VIS_P + H_FP_P),
    .SYNC_END   (H_VIS_P + H_FP_P + H_SYNC_P - 1)
  ) u_h (
    .clk   (clk_50),
    .rst_n (rst_n),
    .en    (pix_en),
    .wrap  (h_wrap),
    .cnt   (X_pix),
    .sync  (h_sync)
  );

  vga_axis_counter #(
    .MAX        (VT - 1),
    .SYNC_START (V_VIS_P + V_FP_P),
    .SYNC_END   (V_VIS_P + V_FP_P + V_SYNC_P - 1)
  ) u_v (
    .clk   (clk_50),
    .rst_n (rst_n),
    .en    (v_en),
    .wrap  (v_wrap),
    .cnt   (Y_pix),
    .sync  (v_sync)
  );

  assign H_visible = X_pix < 10'(H_VIS_P);
  assign V_visible = Y_pix < 10'(V_VIS_P);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      pixel_cnt   <= '0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      if (h_wrap) begin
        pixel_cnt <= '0;
      end else if (H_visible &&
                   pixel_cnt < 10'(H_VIS_P)) begin
        pixel_cnt <= pixel_cnt + 10'd1;
      end
      // Registered so it is high exactly while X=Y=0.
      frame_start <= h_wrap && v_wrap;
    end
  end

  pix_ctl_t cur, tap;

  always_comb begin
    cur     = ctl_rst();
    cur.vis = H_visible && V_visible;
    cur.hs  = h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    cur.vs  = v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
`ifdef VGA_TEST_PATTERN_EN
    cur.bar = 3'(X_pix / 10'd80);
`endif
  end

  // COLOR_DLY-1 stages here; the pin register is the last stage.
  generate
    if (COLOR_DLY > 1) begin : g_dly
      pix_ctl_t dly [COLOR_DLY-1];
      always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < COLOR_DLY-1; i++)
            dly[i] <= ctl_rst();
        end else if (pix_en) begin
          dly[0] <= cur;
          for (int i = 1; i < COLOR_DLY-1; i++)
            dly[i] <= dly[i-1];
        end
      end
      assign tap = dly[COLOR_DLY-2];
    end else begin : g_nodly
      assign tap = cur;
    end
  endgenerate

  rgb12_t src;
`ifdef VGA_TEST_PATTERN_EN
  assign src = bar_color(tap.bar);
`else
  assign src = rgb12_t'(pixel_color);
`endif

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      VGA_BUS_R <= '0;
      VGA_BUS_G <= '0;
      VGA_BUS_B <= '0;
      VGA_HS    <= ~SYNC_ACTIVE;
      VGA_VS    <= ~SYNC_ACTIVE;
    end else if (pix_en) begin
      VGA_BUS_R <= tap.vis ? src.r : 4'd0;
      VGA_BUS_G <= tap.vis ? src.g : 4'd0;
      VGA_BUS_B <= tap.vis ? src.b : 4'd0;
      VGA_HS    <= tap.hs;
      VGA_VS    <= tap.vs;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench, full 800-px lines with a short 15-line frame.
// Checks reset, pix_en cadence, counters, syncs, blanking, colour latency, mid-frame reset.
module tb_vga_timing_gen;

  localparam int VV = 8;
  localparam int VS0 = 10;
  localparam int VS1 = 11;
  localparam int VT = 15;
  localparam int HT = 800;
  localparam int FRAME_PIX = HT * VT;

  logic        clk_50 = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pixel_color = '0;
  logic        pixel_clk, pix_en;
  logic [9:0]  X_pix, Y_pix, pixel_cnt;
  logic        H_visible, V_visible, frame_start;
  logic [3:0]  VGA_BUS_R, VGA_BUS_G, VGA_BUS_B;
  logic        VGA_HS, VGA_VS;

  int passed = 0;
  int total = 0;
  int cyc = 0;

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  vga_timing_gen #(
    .V_VIS_P   (VV),
    .V_FP_P    (2),
    .V_SYNC_P  (2),
    .V_BP_P    (3),
    .COLOR_DLY (1)
  ) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .pixel_color (pixel_color),
    .pixel_clk   (pixel_clk),
    .pix_en      (pix_en),
    .X_pix       (X_pix),
    .Y_pix       (Y_pix),
    .H_visible   (H_visible),
    .V_visible   (V_visible),
    .pixel_cnt   (pixel_cnt),
    .frame_start (frame_start),
    .VGA_BUS_R   (VGA_BUS_R),
    .VGA_BUS_G   (VGA_BUS_G),
    .VGA_BUS_B   (VGA_BUS_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] rgb();
    return 32'({VGA_BUS_B, VGA_BUS_G, VGA_BUS_R});
  endfunction

  int          x, y, fs_seen, fs_cyc0, fs_cyc1;
  logic        pv_vis, pv_hs, pv_vs, first;
  logic [11:0] col;
  logic [11:0] pv_col;
  logic [2:0]  bidx;

  initial begin
    repeat (3) @(negedge clk_50);
    check("rst_pclk", 32'(pixel_clk), 0);
    check("rst_pen", 32'(pix_en), 0);
    check("rst_x", 32'(X_pix), 0);
    check("rst_y", 32'(Y_pix), 0);
    check("rst_pcnt", 32'(pixel_cnt), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_rgb", rgb(), 0);
    check("rst_hs", 32'(VGA_HS), 1);
    check("rst_vs", 32'(VGA_VS), 1);

    rst_n = 1'b1;
    @(negedge clk_50);
    check("rel1_pclk", 32'(pixel_clk), 1);
    check("rel1_pen", 32'(pix_en), 0);
    @(negedge clk_50);
    check("rel2_pen", 32'(pix_en), 1);

    x = 0; y = 0;
    pv_vis = 1'b0; pv_hs = 1'b1; pv_vs = 1'b1;
    pv_col = '0; first = 1'b1;
    fs_seen = 0; fs_cyc0 = 0; fs_cyc1 = 0;

    for (int k = 0; k < 2*FRAME_PIX + VS1*HT + 700; k++) begin
      check("pix_en", 32'(pix_en), 1);
      check("x", 32'(X_pix), 32'(x));
      check("y", 32'(Y_pix), 32'(y));
      check("h_vis", 32'(H_visible), 32'(x < 640));
      check("v_vis", 32'(V_visible), 32'(y < VV));
      check("pcnt", 32'(pixel_cnt),
            32'(x <= 640 ? x : 640));
      check("fs", 32'(frame_start),
            32'(x == 0 && y == 0 && !first));
      check("rgb", rgb(), pv_vis ? 32'(pv_col) : 0);
      check("hs", 32'(VGA_HS), 32'(pv_hs));
      check("vs", 32'(VGA_VS), 32'(pv_vs));
      if (frame_start) begin
        fs_seen++;
        if (fs_seen == 1) fs_cyc0 = cyc;
        if (fs_seen == 2) fs_cyc1 = cyc;
      end

      pixel_color = (k < FRAME_PIX) ? 12'hFFF : 12'(x);
`ifdef VGA_TEST_PATTERN_EN
      bidx = 3'(x / 80);
      col = {{4{bidx[2]}}, {4{bidx[1]}}, {4{bidx[0]}}};
      if (x == 85) check("bar85", 32'(col), 32'h00F);
      if (x == 639) check("bar639", 32'(col), 32'hFFF);
`else
      bidx = '0;
      col = pixel_color;
`endif
      pv_vis = (x < 640) && (y < VV);
      pv_hs  = !(x >= 656 && x <= 751);
      pv_vs  = !(y >= VS0 && y <= VS1);
      pv_col = col;
      first  = 1'b0;
      x++;
      if (x == HT) begin
        x = 0;
        y = (y == VT-1) ? 0 : y + 1;
      end

      @(negedge clk_50);
      if (k < 3) check("pen_low", 32'(pix_en), 0);
      @(negedge clk_50);
    end

    check("fs_count", 32'(fs_seen), 2);
    check("fs_period", 32'(fs_cyc1 - fs_cyc0),
          32'(2 * FRAME_PIX));

    check("mid_x", 32'(X_pix), 700);
    check("mid_y", 32'(Y_pix), 32'(VS1));
    check("mid_hs", 32'(VGA_HS), 0);
    check("mid_vs", 32'(VGA_VS), 0);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_hs", 32'(VGA_HS), 1);
    check("mrst_vs", 32'(VGA_VS), 1);
    check("mrst_rgb", rgb(), 0);
    check("mrst_x", 32'(X_pix), 0);
    check("mrst_y", 32'(Y_pix), 0);
    check("mrst_pcnt", 32'(pixel_cnt), 0);
    check("mrst_pclk", 32'(pixel_clk), 0);

    @(negedge clk_50);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50);
    check("rs_pen", 32'(pix_en), 1);
    check("rs_x0", 32'(X_pix), 0);
    check("rs_y0", 32'(Y_pix), 0);
    check("rs_hs", 32'(VGA_HS), 1);
    repeat (2) @(negedge clk_50);
    check("rs_x1", 32'(X_pix), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
